// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: instruction field
// positions, the link register number and the next-PC select encoding.
package pc_pkg;

    // Instruction field slices
    localparam int IMM_LSB = 0;
    localparam int IMM_MSB = 15;
    localparam int TGT_LSB = 0;
    localparam int TGT_MSB = 25;
    localparam int RS_LSB  = 21;
    localparam int RS_MSB  = 25;

    // Register holding the return address written by JAL
    localparam logic [4:0] RA_REG = 5'd31;

    // Which source feeds the PC register on the next edge
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_EXC
    } next_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the decode/execute side and the PC stage.
// The master drives flow controls; the slave (pc_unit) returns PC state.
interface pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic [31:0]       instr;
    logic              branch;
    logic              branch_ne;
    logic              zero;
    logic              jump;
    logic              link;
    logic              jr;
    logic [ADDR_W-1:0] jr_target;
    logic              exc;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] epc;
    logic              ras_empty;
    logic              ras_mismatch;
    logic              ras_overflow;

    modport master (
        output stall, instr, branch, branch_ne, zero, jump, link, jr,
               jr_target, exc,
        input  pc, pc_plus4, epc, ras_empty, ras_mismatch, ras_overflow
    );

    modport slave (
        input  stall, instr, branch, branch_ne, zero, jump, link, jr,
               jr_target, exc,
        output pc, pc_plus4, epc, ras_empty, ras_mismatch, ras_overflow
    );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address shadow stack. A push onto a full stack overwrites
// the oldest entry and sets a sticky overflow flag; a pop on empty is ignored.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;      // next free slot; wraps at DEPTH
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Pointer, occupancy and sticky overflow update; push has precedence
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Stack bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Entry storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

    assign top_idx  = ptr_q - 1'b1;
    assign top      = mem_q[top_idx];
    assign empty    = (cnt_q == '0);
    assign overflow = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// Registered program counter: next-PC selection for sequential, branch,
// jump, jump-register and exception flows, EPC capture, stall, and a
// return-address shadow stack that cross-checks every jr $31.
module pc_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0040_0000,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_unit_if.slave bus
);
    // Mask of the address bits replaced by a J/JAL target
    localparam logic [ADDR_W-1:0] LOW28 = ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              mm_q, mm_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [17:0]       br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] next_pc;
    logic              br_taken;
    logic              rs_is_ra;
    next_sel_e         sel;

    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_ovf;

    // Opcode bits are decoded elsewhere
    logic unused_opcode;
    assign unused_opcode = ^bus.instr[31:26];

    // Target arithmetic and next-PC selection by flow priority
    always_comb begin
        pc_plus4  = pc_q + ADDR_W'(4);
        br_off    = {bus.instr[IMM_MSB:IMM_LSB], 2'b00};
        br_target = pc_plus4 + {{(ADDR_W-18){br_off[17]}}, br_off};
        j_target  = (pc_plus4 & ~LOW28)
                  | ADDR_W'({bus.instr[TGT_MSB:TGT_LSB], 2'b00});
        br_taken  = bus.branch & (bus.branch_ne ? ~bus.zero : bus.zero);
        rs_is_ra  = (bus.instr[RS_MSB:RS_LSB] == RA_REG);

        sel = SEL_SEQ;
        if (bus.exc) begin
            sel = SEL_EXC;
        end else if (bus.jump) begin
            sel = SEL_J;
        end else if (bus.jr) begin
            sel = SEL_JR;
        end else if (br_taken) begin
            sel = SEL_BR;
        end

        case (sel)
            SEL_EXC: next_pc = ADDR_W'(EXC_VEC);
            SEL_J:   next_pc = j_target;
            SEL_JR:  next_pc = bus.jr_target;
            SEL_BR:  next_pc = br_target;
            default: next_pc = pc_plus4;
        endcase
    end

    // State updates gated by stall; RAS side effects only on winning flows
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        mm_d     = 1'b0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!bus.stall) begin
            pc_d     = next_pc;
            if (sel == SEL_EXC) begin
                epc_d = pc_q;
            end
            ras_push = (sel == SEL_J) && bus.link;
            ras_pop  = (sel == SEL_JR) && rs_is_ra && !ras_empty;
            mm_d     = ras_pop && (ras_top != bus.jr_target);
        end
    end

    // PC, EPC and mismatch-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= ADDR_W'(RESET_VEC);
            epc_q <= '0;
            mm_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mm_q  <= mm_d;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_ovf)
    );

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.epc          = epc_q;
    assign bus.ras_empty    = ras_empty;
    assign bus.ras_mismatch = mm_q & ~bus.stall;
    assign bus.ras_overflow = ras_ovf;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed flows with literal expectations
// plus a queue-based reference model compared on every falling clock edge.
`timescale 1ns/1ps
module tb_pc_unit;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_V  = 32'h0040_0000;
    localparam logic [31:0] EXC_V  = 32'h8000_0180;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_unit_if #(.ADDR_W(ADDR_W)) ifc ();

    pc_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RST_V),
        .EXC_VEC   (EXC_V),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_epc;
    logic [31:0] m_ras[$];
    bit          m_ovf, m_mm;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] p4, popped;
        if (!rst_n) begin
            m_pc  = RST_V;
            m_epc = 32'd0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_mm  = 1'b0;
        end else if (ifc.stall) begin
            m_mm = 1'b0;
        end else begin
            p4   = m_pc + 32'd4;
            m_mm = 1'b0;
            if (ifc.exc) begin
                m_epc = m_pc;
                m_pc  = EXC_V;
            end else if (ifc.jump) begin
                if (ifc.link) begin
                    m_ras.push_back(p4);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                m_pc = {p4[31:28], ifc.instr[25:0], 2'b00};
            end else if (ifc.jr) begin
                if (ifc.instr[25:21] == 5'd31 && m_ras.size() > 0) begin
                    popped = m_ras.pop_back();
                    m_mm   = (popped != ifc.jr_target);
                end
                m_pc = ifc.jr_target;
            end else if (ifc.branch && (ifc.branch_ne ? !ifc.zero : ifc.zero)) begin
                m_pc = p4 + ({{16{ifc.instr[15]}}, ifc.instr[15:0]} << 2);
            end else begin
                m_pc = p4;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("pc",           ifc.pc,           m_pc);
        check("pc_plus4",     ifc.pc_plus4,     m_pc + 32'd4);
        check("epc",          ifc.epc,          m_epc);
        check("ras_empty",    ifc.ras_empty,    m_ras.size() == 0);
        check("ras_overflow", ifc.ras_overflow, m_ovf);
        check("ras_mismatch", ifc.ras_mismatch, m_mm && !ifc.stall);
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        ifc.stall     = 1'b0;
        ifc.instr     = 32'd0;
        ifc.branch    = 1'b0;
        ifc.branch_ne = 1'b0;
        ifc.zero      = 1'b0;
        ifc.jump      = 1'b0;
        ifc.link      = 1'b0;
        ifc.jr        = 1'b0;
        ifc.jr_target = 32'd0;
        ifc.exc       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seq();
        clr();
        tick();
    endtask

    task automatic jal(input logic [25:0] t);
        clr();
        ifc.jump  = 1'b1;
        ifc.link  = 1'b1;
        ifc.instr = {6'b000011, t};
        tick();
    endtask

    task automatic jr_to(input logic [4:0] rs, input logic [31:0] tgt);
        clr();
        ifc.jr        = 1'b1;
        ifc.instr     = {6'b000000, rs, 21'd0};
        ifc.jr_target = tgt;
        tick();
    endtask

    task automatic branch_op(input bit ne, input bit z, input logic [15:0] imm);
        clr();
        ifc.branch    = 1'b1;
        ifc.branch_ne = ne;
        ifc.zero      = z;
        ifc.instr     = {16'h1000, imm};
        tick();
    endtask

    // Upper bound on simulated time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] pops [4];
        pops[0] = 32'h0040_0134;
        pops[1] = 32'h0040_0124;
        pops[2] = 32'h0040_0114;
        pops[3] = 32'h0040_0104;

        clr();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc",    ifc.pc, 32'h0040_0000);
        check("rst_empty", ifc.ras_empty, 1'b1);
        check("rst_epc",   ifc.epc, 32'd0);
        check("rst_ovf",   ifc.ras_overflow, 1'b0);
        check("rst_mm",    ifc.ras_mismatch, 1'b0);

        rst_n = 1'b1;
        seq(); check("seq1", ifc.pc, 32'h0040_0004);
        seq(); check("seq2", ifc.pc, 32'h0040_0008);
        seq(); seq(); check("seq4", ifc.pc, 32'h0040_0010);

        branch_op(1'b0, 1'b1, 16'hFFFC);
        check("beq_back", ifc.pc, 32'h0040_0004);
        repeat (3) seq();
        check("seq_to_10", ifc.pc, 32'h0040_0010);
        branch_op(1'b1, 1'b1, 16'hFFFC);
        check("bne_not_taken", ifc.pc, 32'h0040_0014);

        // JAL / jr $31 match and mismatch
        jr_to(5'd0, 32'h0040_0020);
        check("jr_rs0", ifc.pc, 32'h0040_0020);
        jal(26'h0100040);
        check("jal_pc",    ifc.pc, 32'h0040_0100);
        check("jal_empty", ifc.ras_empty, 1'b0);
        jr_to(5'd31, 32'h0040_0024);
        check("ret_pc",    ifc.pc, 32'h0040_0024);
        check("ret_mm",    ifc.ras_mismatch, 1'b0);
        check("ret_empty", ifc.ras_empty, 1'b1);
        jr_to(5'd0, 32'h0040_0020);
        jal(26'h0100040);
        jr_to(5'd31, 32'h0040_0028);
        check("bad_ret_pc", ifc.pc, 32'h0040_0028);
        check("bad_ret_mm", ifc.ras_mismatch, 1'b1);
        seq();
        check("mm_one_cycle", ifc.ras_mismatch, 1'b0);

        // Overflow: five pushes into four entries
        jal(26'h0100040);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) check("ovf_before_5th", ifc.ras_overflow, 1'b0);
            jal(26'h0100040 + 26'(4 * k));
        end
        check("ovf_pc",  ifc.pc, 32'h0040_0140);
        check("ovf_set", ifc.ras_overflow, 1'b1);
        for (int k = 0; k < 4; k++) begin
            jr_to(5'd31, pops[k]);
            check("lifo_pc", ifc.pc, pops[k]);
            check("lifo_mm", ifc.ras_mismatch, 1'b0);
        end
        check("lifo_empty", ifc.ras_empty, 1'b1);
        jr_to(5'd31, 32'h0040_0030);
        check("empty_pop_mm", ifc.ras_mismatch, 1'b0);
        check("ovf_sticky",   ifc.ras_overflow, 1'b1);

        // Exception priority and stall
        jal(26'h0100010);
        check("jal_to_40", ifc.pc, 32'h0040_0040);
        clr();
        ifc.exc = 1'b1; ifc.jump = 1'b1; ifc.link = 1'b1;
        ifc.instr = {6'b000011, 26'h0100040};
        tick();
        check("exc_pc",    ifc.pc, 32'h8000_0180);
        check("exc_epc",   ifc.epc, 32'h0040_0040);
        check("exc_ras",   ifc.ras_empty, 1'b0);
        clr();
        ifc.stall = 1'b1; ifc.exc = 1'b1; ifc.jump = 1'b1; ifc.link = 1'b1;
        tick();
        check("stall_pc",  ifc.pc, 32'h8000_0180);
        check("stall_epc", ifc.epc, 32'h0040_0040);
        seq();
        check("post_stall", ifc.pc, 32'h8000_0184);
        jr_to(5'd31, 32'h0040_0034);
        check("ras_intact_mm",    ifc.ras_mismatch, 1'b0);
        check("ras_intact_empty", ifc.ras_empty, 1'b1);

        // Mismatch pulse is masked while stalled
        jal(26'h0100040);
        jr_to(5'd31, 32'h0000_0000);
        clr();
        ifc.stall = 1'b1;
        #1;
        check("mm_stall_mask", ifc.ras_mismatch, 1'b0);
        tick();
        seq();
        check("after_mask_pc", ifc.pc, 32'h0000_0004);

        // Jump and jr together: jump wins, push only
        jal(26'h0100040);
        clr();
        ifc.jump = 1'b1; ifc.link = 1'b1; ifc.jr = 1'b1;
        ifc.instr = {6'b000011, 5'd31, 21'd0};
        ifc.jr_target = 32'h1234_5678;
        tick();
        check("j_over_jr_pc",    ifc.pc, 32'h0F80_0000);
        check("j_over_jr_empty", ifc.ras_empty, 1'b0);

        // Asynchronous reset between clock edges
        clr();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc",    ifc.pc, 32'h0040_0000);
        check("async_rst_empty", ifc.ras_empty, 1'b1);
        check("async_rst_ovf",   ifc.ras_overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seq();
        check("after_rst_pc", ifc.pc, 32'h0040_0004);
        seq();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter stage for the MIPS core, replacing the combinational next-PC logic.
- Holds the PC, computes the next PC for sequential, branch, jump, jump-register and exception flows, and supports a pipeline stall.
- Contains a parametrised return-address shadow stack (RAS). The stack records JAL return addresses and checks each `jr $31` against them, flagging mismatches for debug.

Parameters:
- ADDR_W, 32, PC width in bits; legal range 28..64.
- RESET_VEC, 32'h0040_0000, PC value after reset (zero-extended to ADDR_W).
- EXC_VEC, 32'h8000_0180, exception handler address (zero-extended to ADDR_W).
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC, EPC and RAS; no state changes.
- instr  in  32  current instruction; uses imm16 [15:0], target26 [25:0] and rs [25:21].
- branch  in  1  conditional branch instruction.
- branch_ne  in  1  branch is taken on !zero (BNE) instead of zero (BEQ).
- zero  in  1  ALU zero flag.
- jump  in  1  J/JAL.
- link  in  1  JAL; only meaningful when jump=1.
- jr  in  1  jump register.
- jr_target  in  ADDR_W  rs register value.
- exc  in  1  exception request.
- pc  out  ADDR_W  current PC.
- pc_plus4  out  ADDR_W  pc+4, combinational.
- epc  out  ADDR_W  PC captured on the last exception.
- ras_empty  out  1  RAS holds no entries.
- ras_mismatch  out  1  one-cycle pulse on a RAS check failure.
- ras_overflow  out  1  sticky; set when a push overwrote the oldest entry.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: pc=RESET_VEC, epc=0, RAS count=0, ras_empty=1, ras_mismatch=0, ras_overflow=0.
- Arithmetic is modulo 2^ADDR_W; carries out of the top bit are dropped.
- pc_plus4 = pc + 4.
- Branch target = pc_plus4 + (sign-extended imm16 << 2).
- Jump target = {pc_plus4[ADDR_W-1:28], target26, 2'b00}.
- Branch is taken when branch & (branch_ne ? !zero : zero).
- Next-PC priority, highest first: exc → EXC_VEC; jump → jump target; jr → jr_target; branch taken → branch target; otherwise pc_plus4.
- Latency is one cycle. The chosen next PC is registered on the rising edge when stall=0.
- stall=1 freezes pc, epc and the RAS, and forces ras_mismatch low. exc under stall is ignored; the requester holds exc until the stall clears.
- On exc, epc ← pc (the faulting instruction) and the RAS is untouched. Flow inputs asserted together with exc have no effect on any state.
- RAS push: on a JAL (jump & link, no exc, no stall), the stack pushes pc_plus4.
- RAS full: when a push arrives with RAS_DEPTH entries, the stack is circular. The oldest entry is overwritten, the count stays at RAS_DEPTH, and ras_overflow is set until reset.
- RAS check/pop: on jr with rs=31, taken with no higher-priority flow and no stall:
  - If not empty: pop; ras_mismatch pulses for one cycle (registered) when the popped entry ≠ jr_target.
  - If empty: no pop, no mismatch.
- jr with rs≠31 does not touch the RAS.
- Simultaneous jump and jr: the jump wins; only the push (if link) occurs and no pop.
- Reset mid-operation clears all state immediately; the first active edge after release fetches from RESET_VEC + 4 (sequential).

Decomposition:
- Shared package `pc_pkg` holds:
  - field slice constants: IMM_LSB/MSB, TGT_LSB/MSB, RS_LSB/MSB;
  - RA_REG = 5'd31;
  - a next-PC select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC}.
- One sub-module is natural: `ras_stack`, parametrised by depth and width, with ports push/pop/push_data/top/empty/overflow and a circular pointer plus count.
- Next-PC mux and PC/EPC registers stay in pc_unit.

Test Plan:
- Reset: hold rst_n=0 → pc=32'h0040_0000, ras_empty=1. Release with all controls 0 → pc = 0x00400004, then 0x00400008.
- Branch taken backwards: pc=0x00400010, branch=1, zero=1, imm16=16'hFFFC → next pc=0x00400004. Same stimulus with branch_ne=1 → 0x00400014.
- JAL then `jr $31`: at pc=0x00400020, jump=link=1, target26=26'h0100040 → pc=0x00400100 and RAS top=0x00400024. Then jr rs=31 with jr_target=0x00400024 → pc=0x00400024, no mismatch, ras_empty=1. Repeat with jr_target=0x00400028 → ras_mismatch pulses once.
- Overflow: 5 consecutive JALs with RAS_DEPTH=4 → ras_overflow=1 (sticky). 4 `jr $31` pops return the last four pushes in LIFO order; the first push is lost.
- Exception priority and stall: exc=1 together with jump=1 at pc=0x00400040 → pc=0x80000180, epc=0x00400040, RAS unchanged. With stall=1 and exc=1 → pc, epc and RAS unchanged.
- Async reset mid-flow: assert rst_n=0 between clock edges after 2 pushes → pc=RESET_VEC and ras_empty=1 immediately, without waiting for a clock edge.
